// File: rtl/spi_dac_sequencer_if.sv
// FIFO-side and DAC-side pins of spi_dac_sequencer.
// With LDAC_SYNC_EN defined the bundle also carries the ldacn strobe.
interface spi_dac_sequencer_if #(
  parameter int unsigned NCH = 2
);
  logic           fifo_empty;
  logic [7:0]     fifo_data;
  logic           fifo_rd;
  logic           SCL;
  logic           MOSI;
  logic [NCH-1:0] CSn;
  logic           busy;
  logic           frame_err;
`ifdef LDAC_SYNC_EN
  logic           ldacn;

  modport master (input fifo_empty, fifo_data,
                  output fifo_rd, SCL, MOSI, CSn, busy, frame_err, ldacn);
  modport slave  (output fifo_empty, fifo_data,
                  input fifo_rd, SCL, MOSI, CSn, busy, frame_err, ldacn);
`else
  modport master (input fifo_empty, fifo_data,
                  output fifo_rd, SCL, MOSI, CSn, busy, frame_err);
  modport slave  (output fifo_empty, fifo_data,
                  input fifo_rd, SCL, MOSI, CSn, busy, frame_err);
`endif
endinterface

// File: rtl/spi_dac_sequencer.sv
// Pops header/value/delay frames from a FWFT byte FIFO, waits the delay, then shifts the
// value out as an SPI mode-0 word on one of NCH chip selects. LDAC_SYNC_EN adds an ldacn pulse.
module spi_dac_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned NCH    = 2,
  parameter int unsigned CLKDIV = 1,
  parameter int unsigned VSHIFT = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  spi_dac_sequencer_if.master  bus
);
  localparam int unsigned PAY_B = DATA_W / 8 + CNT_W / 8;
  localparam int unsigned FRM_W = DATA_W + CNT_W;
  localparam int unsigned BC_W  = $clog2(PAY_B + 1);
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);
  localparam int unsigned DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  typedef enum logic [2:0] {IDLE, COLLECT, WAIT, SEND, DONE, ERR, LDAC} state_t;

  state_t             r_state, w_state;
  logic [3:0]         r_ch, w_ch;
  logic [FRM_W-9:0]   r_frm, w_frm;
  logic [BC_W-1:0]    r_bcnt, w_bcnt;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [DATA_W-1:0]  r_shift, w_shift;
  logic [DIV_W-1:0]   r_div, w_div;
  logic               r_scl, w_scl;
  logic [BIT_W-1:0]   r_bit, w_bit;
  logic [NCH-1:0]     r_csn, w_csn;
  logic               r_mosi, w_mosi;
  logic               r_busy, w_busy;
  logic               r_ferr, w_ferr;
  logic               w_rd;
  logic [FRM_W-1:0]   w_frm_in;
  logic [NCH-1:0]     w_sel;
`ifdef LDAC_SYNC_EN
  logic               r_hold, w_hold;
  logic               r_ldacn, w_ldacn;
`endif

  assign w_frm_in = {r_frm, bus.fifo_data};
  assign w_sel    = ~(NCH'(1) << r_ch);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_ch    <= '0;
      r_frm   <= '0;
      r_bcnt  <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_div   <= '0;
      r_scl   <= 1'b0;
      r_bit   <= '0;
      r_csn   <= '1;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef LDAC_SYNC_EN
      r_hold  <= 1'b0;
      r_ldacn <= 1'b1;
`endif
    end else begin
      r_state <= w_state;
      r_ch    <= w_ch;
      r_frm   <= w_frm;
      r_bcnt  <= w_bcnt;
      r_cnt   <= w_cnt;
      r_shift <= w_shift;
      r_div   <= w_div;
      r_scl   <= w_scl;
      r_bit   <= w_bit;
      r_csn   <= w_csn;
      r_mosi  <= w_mosi;
      r_busy  <= w_busy;
      r_ferr  <= w_ferr;
`ifdef LDAC_SYNC_EN
      r_hold  <= w_hold;
      r_ldacn <= w_ldacn;
`endif
    end
  end

  always_comb begin
    w_state = r_state;
    w_ch    = r_ch;
    w_frm   = r_frm;
    w_bcnt  = r_bcnt;
    w_cnt   = r_cnt;
    w_shift = r_shift;
    w_div   = r_div;
    w_scl   = r_scl;
    w_bit   = r_bit;
    w_csn   = r_csn;
    w_mosi  = r_mosi;
    w_busy  = r_busy;
    w_ferr  = 1'b0;
    w_rd    = 1'b0;
`ifdef LDAC_SYNC_EN
    w_hold  = r_hold;
    w_ldacn = r_ldacn;
`endif
    case (r_state)
      IDLE: begin
        w_rd = resetn & ~bus.fifo_empty;
        if (w_rd) begin
          w_ch    = bus.fifo_data[3:0];
`ifdef LDAC_SYNC_EN
          w_hold  = bus.fifo_data[7];
`endif
          w_bcnt  = '0;
          w_busy  = 1'b1;
          w_state = COLLECT;
        end
      end
      COLLECT: begin
        w_rd = resetn & ~bus.fifo_empty;
        if (w_rd) begin
          w_frm  = w_frm_in[FRM_W-9:0];
          w_bcnt = r_bcnt + BC_W'(1);
          // Last payload byte: value and delay are complete in w_frm_in this cycle.
          if (r_bcnt == BC_W'(PAY_B - 1)) begin
            if ({1'b0, r_ch} >= 5'(NCH)) begin
              w_ferr  = 1'b1;
              w_state = ERR;
            end else begin
              w_cnt   = w_frm_in[CNT_W-1:0];
              w_shift = w_frm_in[FRM_W-1 -: DATA_W] >> VSHIFT;
              w_state = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_csn   = w_sel;
          w_mosi  = r_shift[DATA_W-1];
          w_scl   = 1'b0;
          w_div   = '0;
          w_bit   = '0;
          w_state = SEND;
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end
      SEND: begin
        // Each bit is CLKDIV cycles low then CLKDIV high; data advances on the fall.
        if (r_div == DIV_W'(CLKDIV - 1)) begin
          w_div = '0;
          if (!r_scl) begin
            w_scl = 1'b1;
          end else begin
            w_scl = 1'b0;
            w_bit = r_bit + BIT_W'(1);
            if (r_bit == BIT_W'(DATA_W - 1)) begin
              w_csn   = '1;
              w_state = DONE;
            end else begin
              w_shift = {r_shift[DATA_W-2:0], 1'b0};
              w_mosi  = r_shift[DATA_W-2];
            end
          end
        end else begin
          w_div = r_div + DIV_W'(1);
        end
      end
      DONE: begin
        w_mosi = 1'b0;
`ifdef LDAC_SYNC_EN
        if (!r_hold) begin
          w_ldacn = 1'b0;
          w_div   = '0;
          w_state = LDAC;
        end else begin
          w_busy  = 1'b0;
          w_state = IDLE;
        end
`else
        w_busy  = 1'b0;
        w_state = IDLE;
`endif
      end
      ERR: begin
        w_busy  = 1'b0;
        w_state = IDLE;
      end
`ifdef LDAC_SYNC_EN
      LDAC: begin
        if (r_div == DIV_W'(CLKDIV - 1)) begin
          w_ldacn = 1'b1;
          w_busy  = 1'b0;
          w_state = IDLE;
        end else begin
          w_div = r_div + DIV_W'(1);
        end
      end
`endif
      default: w_state = IDLE;
    endcase
  end

  assign bus.fifo_rd   = w_rd;
  assign bus.SCL       = r_scl;
  assign bus.MOSI      = r_mosi;
  assign bus.CSn       = r_csn;
  assign bus.busy      = r_busy;
  assign bus.frame_err = r_ferr;
`ifdef LDAC_SYNC_EN
  assign bus.ldacn     = r_ldacn;
`endif
endmodule

// File: tb/tb_spi_dac_sequencer.sv
// Scoreboard bench for spi_dac_sequencer: DUT 0 uses CLKDIV=1, DUT 1 uses CLKDIV=3.
module tb_spi_dac_sequencer;
  localparam int unsigned NCH = 2;
  localparam int K_SPI = 0, K_ERR = 1, K_NONE = 2;
  localparam int W_CSLOW = 0, W_CSHIGH = 1, W_IDLE = 2, W_RISE8 = 3;

  typedef struct {
    int          kind;
    int          ch;
    logic [15:0] word;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic       d_empty [2] = '{1'b1, 1'b1};
  logic [7:0] d_data  [2] = '{8'h00, 8'h00};
  logic [1:0] m_csn   [2];
  logic       m_scl [2], m_mosi [2], m_busy [2], m_ferr [2], m_rd [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    spi_dac_sequencer_if #(.NCH(NCH)) bus ();
    assign bus.fifo_empty = d_empty[g];
    assign bus.fifo_data  = d_data[g];
    assign m_csn[g]  = bus.CSn;
    assign m_scl[g]  = bus.SCL;
    assign m_mosi[g] = bus.MOSI;
    assign m_busy[g] = bus.busy;
    assign m_ferr[g] = bus.frame_err;
    assign m_rd[g]   = bus.fifo_rd;
    spi_dac_sequencer #(
      .DATA_W(16), .CNT_W(16), .NCH(NCH), .CLKDIV((g == 0) ? 1 : 3), .VSHIFT(2)
    ) u_dut (
      .clk(clk), .resetn(resetn), .bus(bus)
    );
  end

  logic [7:0] fifo_q [2][$];
  exp_t       exp_q  [2][$];
  int pops [2] = '{0, 0};
  int bytes_in [2] = '{0, 0};
  int last_pop [2] = '{0, 0};
  int rd_viol = 0;
  int cyc = 0;
  bit pend [2] = '{1'b0, 1'b0};

  bit         in_f [2] = '{1'b0, 1'b0};
  int         cs_cyc [2], rises [2], run [2], badrun [2], onehot_bad [2], lat_meas [2];
  logic [15:0] word [2];
  logic [1:0] cs_first [2];
  logic       prev_scl [2];
  logic       prev_ferr [2] = '{1'b0, 1'b0};
  bit         chk_busy [2] = '{1'b0, 1'b0};

  function automatic int cdiv(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO model: a byte the DUT strobed at the previous negedge is consumed on this posedge.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      if (pend[d] && fifo_q[d].size() > 0) fifo_q[d].delete(0);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (fifo_q[d].size() == 0) begin
        d_empty[d] = 1'b1;
        d_data[d]  = 8'h00;
      end else begin
        d_empty[d] = 1'b0;
        d_data[d]  = fifo_q[d][0];
      end
    end
  end

  // Monitor: reconstructs SPI words and error pulses and checks them against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   ach;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!resetn) begin
        pend[d] = 1'b0;
        in_f[d] = 1'b0;
        prev_ferr[d] = 1'b0;
        chk_busy[d] = 1'b0;
      end else begin
        pend[d] = m_rd[d];
        if (pend[d]) begin
          pops[d]++;
          last_pop[d] = cyc;
          if (d_empty[d]) rd_viol++;
        end
        if (chk_busy[d]) begin
          chk("err_pulse_then_idle", 32'({m_ferr[d], m_busy[d]}), 32'd0);
          chk_busy[d] = 1'b0;
        end
        if (m_ferr[d] && !prev_ferr[d]) begin
          if (exp_q[d].size() == 0) chk("unexpected_frame_err", 32'd1, 32'd0);
          else begin
            e = exp_q[d].pop_front();
            chk("err_kind", 32'(e.kind), 32'(K_ERR));
          end
          chk_busy[d] = 1'b1;
        end
        prev_ferr[d] = m_ferr[d];

        if (!in_f[d]) begin
          if (m_csn[d] != 2'b11) begin
            in_f[d] = 1'b1;
            cs_first[d] = m_csn[d];
            cs_cyc[d] = 1;
            rises[d] = 0;
            word[d] = 16'h0;
            run[d] = 1;
            badrun[d] = m_scl[d] ? 1 : 0;
            onehot_bad[d] = (m_csn[d] == 2'b01 || m_csn[d] == 2'b10) ? 0 : 1;
            prev_scl[d] = m_scl[d];
            lat_meas[d] = cyc - 1 - last_pop[d];
          end
        end else if (m_csn[d] != 2'b11) begin
          cs_cyc[d]++;
          if (m_csn[d] != cs_first[d]) onehot_bad[d]++;
          if (m_scl[d] == prev_scl[d]) run[d]++;
          else begin
            if (run[d] != cdiv(d)) badrun[d]++;
            run[d] = 1;
          end
          if (m_scl[d] && !prev_scl[d]) begin
            rises[d]++;
            word[d] = {word[d][14:0], m_mosi[d]};
          end
          prev_scl[d] = m_scl[d];
        end else begin
          in_f[d] = 1'b0;
          if (run[d] != cdiv(d)) badrun[d]++;
          if (m_scl[d]) badrun[d]++;
          if (exp_q[d].size() == 0) chk("unexpected_spi_frame", 32'd1, 32'd0);
          else begin
            e = exp_q[d].pop_front();
            ach = (cs_first[d] == 2'b10) ? 0 : (cs_first[d] == 2'b01) ? 1 : 99;
            chk("spi_kind", 32'(K_SPI), 32'(e.kind));
            chk("spi_channel", 32'(ach), 32'(e.ch));
            chk("spi_word", 32'(word[d]), 32'(e.word));
            chk("spi_start_latency", 32'(lat_meas[d]), 32'(e.lat));
            chk("cs_low_cycles", 32'(cs_cyc[d]), 32'(32 * cdiv(d)));
            chk("scl_rises", 32'(rises[d]), 32'd16);
            chk("scl_half_periods", 32'(badrun[d]), 32'd0);
            chk("cs_onehot", 32'(onehot_bad[d]), 32'd0);
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input int d, input logic [7:0] h, input logic [15:0] v,
                            input logic [15:0] dl, input int gap, input int kind,
                            input int ch, input logic [15:0] w, input int lat);
    exp_t       e;
    logic [7:0] b [5];
    if (kind != K_NONE) begin
      e.kind = kind;
      e.ch   = ch;
      e.word = w;
      e.lat  = lat;
      exp_q[d].push_back(e);
    end
    b[0] = h;
    b[1] = v[15:8];
    b[2] = v[7:0];
    b[3] = dl[15:8];
    b[4] = dl[7:0];
    for (int i = 0; i < 5; i++) begin
      if (i > 0) repeat (gap) step();
      fifo_q[d].push_back(b[i]);
      bytes_in[d]++;
    end
  endtask

  function automatic bit cond(input int d, input int what);
    case (what)
      W_CSLOW:  return m_csn[d] != 2'b11;
      W_CSHIGH: return m_csn[d] == 2'b11;
      W_IDLE:   return !m_busy[d] && fifo_q[d].size() == 0 && m_csn[d] == 2'b11 && !in_f[d];
      W_RISE8:  return in_f[d] && rises[d] == 8;
      default:  return 1'b1;
    endcase
  endfunction

  task automatic wait_until(input int d, input int what, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (cond(d, what)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL timeout_%s: condition not reached within %0d cycles", name, budget);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    resetn = 1'b0;
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      chk("reset_csn", 32'(m_csn[d]), 32'h3);
      chk("reset_scl", 32'(m_scl[d]), 32'h0);
      chk("reset_mosi", 32'(m_mosi[d]), 32'h0);
      chk("reset_busy", 32'(m_busy[d]), 32'h0);
      chk("reset_frame_err", 32'(m_ferr[d]), 32'h0);
      chk("reset_fifo_rd", 32'(m_rd[d]), 32'h0);
    end
    resetn = 1'b1;
    step();

    // Back-to-back frames with the FIFO kept full: ch1 0x1234>>2, delay 3; ch0 0xABCD>>2, delay 0.
    send_frame(0, 8'h01, 16'h1234, 16'h0003, 0, K_SPI, 1, 16'h048D, 4);
    send_frame(0, 8'h80, 16'hABCD, 16'h0000, 0, K_SPI, 0, 16'h2AF3, 1);
    wait_until(0, W_CSLOW, 200, "t1_cs_low");
    chk("pops_at_cs_fall", 32'(pops[0]), 32'd5);
    wait_until(0, W_CSHIGH, 200, "t1_cs_high");
    chk("pops_at_cs_rise", 32'(pops[0]), 32'd5);
    wait_until(0, W_IDLE, 300, "t1_idle");

    // Bad channels 7 and 5 (NCH=2): whole frame consumed, error pulse only.
    send_frame(0, 8'h07, 16'h1122, 16'h3344, 0, K_ERR, 0, 16'h0, 0);
    send_frame(0, 8'h05, 16'h1234, 16'h0003, 0, K_ERR, 0, 16'h0, 0);
    wait_until(0, W_IDLE, 200, "t2_idle");
    chk("pops_after_err_frames", 32'(pops[0]), 32'd20);
    chk("csn_after_err_frames", 32'(m_csn[0]), 32'h3);

    // CLKDIV=3, zero delay, all-ones value.
    send_frame(1, 8'h00, 16'hFFFF, 16'h0000, 0, K_SPI, 0, 16'h3FFF, 1);
    wait_until(1, W_IDLE, 400, "t3_idle");

    // Bytes spaced 10 cycles apart, delay 10.
    send_frame(1, 8'h01, 16'h5678, 16'h000A, 10, K_SPI, 1, 16'h159E, 11);
    wait_until(1, W_IDLE, 400, "t4_idle");
    chk("pops_dut1", 32'(pops[1]), 32'd10);

    // Reset in the middle of a shift, then a fresh frame.
    send_frame(0, 8'h01, 16'h8000, 16'h0002, 0, K_NONE, 0, 16'h0, 0);
    wait_until(0, W_RISE8, 200, "t5_bit8");
    resetn = 1'b0;
    #1;
    chk("abort_csn", 32'(m_csn[0]), 32'h3);
    chk("abort_scl", 32'(m_scl[0]), 32'h0);
    chk("abort_busy", 32'(m_busy[0]), 32'h0);
    step();
    step();
    resetn = 1'b1;
    step();
    send_frame(0, 8'h00, 16'hC35A, 16'h0001, 0, K_SPI, 0, 16'h30D6, 2);
    wait_until(0, W_IDLE, 300, "t5_idle");

    repeat (5) step();
    chk("scoreboard_empty_0", 32'(exp_q[0].size()), 32'd0);
    chk("scoreboard_empty_1", 32'(exp_q[1].size()), 32'd0);
    chk("all_bytes_popped_0", 32'(pops[0]), 32'(bytes_in[0]));
    chk("all_bytes_popped_1", 32'(pops[1]), 32'(bytes_in[1]));
    chk("rd_while_empty", 32'(rd_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
